// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings as emitted by
// the E-stage control decoder, and the default MIPS latencies.
package mdu_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at start, held pending, and committed after a fixed latency.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW   = $clog2(MAXC + 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   state_e        state;
   logic [CW-1:0] cnt;
   logic [31:0]   pend_hi;
   logic [31:0]   pend_lo;
   logic          pend_wr;

   logic [63:0]   prod_s;
   logic [63:0]   prod_u;
   logic [31:0]   dvs;
   logic [31:0]   sq, sr, uq, ur;

   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'b0, A} * {32'b0, B};

   // Divisor forced nonzero so the dividers never yield X; a zero divide never commits.
   assign dvs = (B == '0) ? 32'd1 : B;

   always_comb begin
      sq = 32'($signed(A) / $signed(dvs));
      sr = 32'($signed(A) % $signed(dvs));
      if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
         sq = 32'h8000_0000;
         sr = '0;
      end
      uq = A / dvs;
      ur = A % dvs;
   end

   assign busy = (state == ST_BUSY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         HI      <= '0;
         LO      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  case (md_op_e'(op))
                     MD_MULT: begin
                        {pend_hi, pend_lo} <= prod_s;
                        pend_wr <= 1'b1;
                        cnt     <= CW'(MULT_CYCLES);
                        state   <= ST_BUSY;
                     end
                     MD_MULTU: begin
                        {pend_hi, pend_lo} <= prod_u;
                        pend_wr <= 1'b1;
                        cnt     <= CW'(MULT_CYCLES);
                        state   <= ST_BUSY;
                     end
                     MD_DIV: begin
                        pend_hi <= sr;
                        pend_lo <= sq;
                        pend_wr <= (B != '0);
                        cnt     <= CW'(DIV_CYCLES);
                        state   <= ST_BUSY;
                     end
                     MD_DIVU: begin
                        pend_hi <= ur;
                        pend_lo <= uq;
                        pend_wr <= (B != '0);
                        cnt     <= CW'(DIV_CYCLES);
                        state   <= ST_BUSY;
                     end
                     MD_MTHI: HI <= A;
                     MD_MTLO: LO <= A;
                     default: ;
                  endcase
               end
            end
            ST_BUSY: begin
               if (cnt == CW'(1)) begin
                  if (pend_wr) begin
                     HI <= pend_hi;
                     LO <= pend_lo;
                  end
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: an arithmetic reference model with a cycle-accurate
// commit schedule, checked every cycle, plus literal expectations per vector.
module tb_mdu;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy;
   logic [31:0] HI, LO;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   // Reference arithmetic on magnitudes and signs with 64-bit integers.
   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      longint unsigned ma, mb, p;
      bit neg;
      neg = sgn && (a[31] ^ b[31]);
      ma = (sgn && a[31]) ? longint'(-$signed({32'b0, a}) + 64'h1_0000_0000) : longint'({32'b0, a});
      mb = (sgn && b[31]) ? longint'(-$signed({32'b0, b}) + 64'h1_0000_0000) : longint'({32'b0, b});
      p = ma * mb;
      return neg ? (64'd0 - p) : p;
   endfunction

   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      longint unsigned ma, mb, q, r;
      ma = (sgn && a[31]) ? (64'h1_0000_0000 - {32'b0, a}) : {32'b0, a};
      mb = (sgn && b[31]) ? (64'h1_0000_0000 - {32'b0, b}) : {32'b0, b};
      q = ma / mb;
      r = ma % mb;
      if (sgn && (a[31] ^ b[31])) q = 64'd0 - q;
      if (sgn && a[31]) r = 64'd0 - r;
      return {r[31:0], q[31:0]};
   endfunction

   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   int          m_rem = 0;
   bit          m_wr = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_hi = '0; m_lo = '0; m_rem = 0; m_wr = 1'b0;
      end else if (m_rem > 0) begin
         if (start) $display("[TB] WARNING: start while busy at %0t, expected to be ignored", $time);
         m_rem = m_rem - 1;
         if (m_rem == 0 && m_wr) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end
      end else if (start) begin
         case (op)
            3'd0, 3'd1: begin
               {p_hi, p_lo} = ref_mul(A, B, op == 3'd0);
               m_wr = 1'b1;
               m_rem = 5;
            end
            3'd2, 3'd3: begin
               m_wr = (B != 0);
               if (B != 0) {p_hi, p_lo} = ref_div(A, B, op == 3'd2);
               m_rem = 10;
            end
            3'd4: m_hi = A;
            3'd5: m_lo = A;
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         tests++;
         if (busy !== (m_rem > 0) || HI !== m_hi || LO !== m_lo) begin
            fails++;
            $display("FAIL model t=%0t busy/HI/LO got %b/%h/%h exp %b/%h/%h",
                     $time, busy, HI, LO, (m_rem > 0), m_hi, m_lo);
         end
      end
   end

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Counts busy-high cycles seen on negedges; bounded so a stuck busy fails cleanly.
   task automatic wait_idle(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) return;
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
   end

   initial begin
      int n;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check32("reset_hi", HI, 32'h0);
      check32("reset_lo", LO, 32'h0);
      check32("reset_busy", {31'b0, busy}, 32'h0);
      @(posedge clk); #1 reset = 1'b1;

      issue(3'd0, 32'hFFFF_FFFF, 32'd2);
      wait_idle(n);
      check32("mult_len", n, 5);
      check32("mult_hi", HI, 32'hFFFF_FFFF);
      check32("mult_lo", LO, 32'hFFFF_FFFE);

      issue(3'd1, 32'hFFFF_FFFF, 32'd2);
      wait_idle(n);
      check32("multu_len", n, 5);
      check32("multu_hi", HI, 32'h0000_0001);
      check32("multu_lo", LO, 32'hFFFF_FFFE);

      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      check32("div_len", n, 10);
      check32("div_lo", LO, 32'hFFFF_FFFD);
      check32("div_hi", HI, 32'hFFFF_FFFF);

      issue(3'd3, 32'd7, 32'd2);
      wait_idle(n);
      check32("divu_lo", LO, 32'd3);
      check32("divu_hi", HI, 32'd1);

      issue(3'd4, 32'h1234_5678, 32'd0);
      issue(3'd5, 32'h9ABC_DEF0, 32'd0);
      @(negedge clk);
      check32("mthi", HI, 32'h1234_5678);
      check32("mtlo", LO, 32'h9ABC_DEF0);
      issue(3'd3, 32'd5, 32'd0);
      wait_idle(n);
      check32("div0_len", n, 10);
      check32("div0_hi", HI, 32'h1234_5678);
      check32("div0_lo", LO, 32'h9ABC_DEF0);

      issue(3'd6, 32'h5555_5555, 32'd1);
      issue(3'd7, 32'hAAAA_AAAA, 32'd1);
      @(negedge clk);
      check32("nop_busy", {31'b0, busy}, 32'h0);
      check32("nop_hi", HI, 32'h1234_5678);

      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      check32("ovf_lo", LO, 32'h8000_0000);
      check32("ovf_hi", HI, 32'h0);

      issue(3'd4, 32'hDEAD_0000, 32'd0);
      @(posedge clk); #1;
      start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd4;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle(n);
      check32("ignored_len", n, 3);
      check32("ignored_hi", HI, 32'h0);
      check32("ignored_lo", LO, 32'd12);

      issue(3'd2, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check32("rst_mid_busy", {31'b0, busy}, 32'h0);
      check32("rst_mid_hi", HI, 32'h0);
      check32("rst_mid_lo", LO, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (15) @(negedge clk);
      check32("rst_nocommit_lo", LO, 32'h0);
      check32("rst_nocommit_busy", {31'b0, busy}, 32'h0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the E stage, downstream of the register file; consumes the two read-port operands (after forwarding).
- Holds architectural HI/LO registers.
- Models fixed MIPS latencies: 5 cycles for MULT/MULTU, 10 for DIV/DIVU.
- Exposes busy so the hazard unit can stall later MD-class instructions (MFHI/MFLO/MTHI/MTLO/next mult/div) in D.

Parameters:
- MULT_CYCLES, 5, cycles busy is high after a MULT/MULTU start.
- DIV_CYCLES, 10, cycles busy is high after a DIV/DIVU start.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); one clock domain only.
- start  input  1  E-stage instruction is an MD op this cycle; single-cycle pulse.
- op  input  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; other codes are no-op.
- A  input  32  rs operand (forwarded RD1).
- B  input  32  rt operand (forwarded RD2).
- busy  output  1  operation in progress.
- HI  output  32  architectural HI register, read by MFHI.
- LO  output  32  architectural LO register, read by MFLO.

Behaviour:
- Reset (reset=0, asynchronous):
  - HI=0, LO=0, busy=0, counter=0, pending results cleared.
  - Takes effect immediately, mid-operation included; any in-flight op is aborted and never commits.
- Idle (busy=0) with start=1 at edge T0:
  - MULT: signed 64-bit product of A*B latched into pending {hi,lo}; busy=1, counter=MULT_CYCLES.
  - MULTU: unsigned product, otherwise same as MULT.
  - DIV: signed; pending lo = quotient truncated toward zero, pending hi = remainder with the sign of the dividend; busy=1, counter=DIV_CYCLES.
    - Special case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient/remainder; busy=1, counter=DIV_CYCLES.
  - Divide by zero (B=0, DIV or DIVU): busy asserted for DIV_CYCLES as normal; HI/LO unchanged at commit.
  - MTHI: HI<=A at T0; MTLO: LO<=A at T0. No busy.
- Counting:
  - Counter decrements on each edge while busy.
  - On the edge where the counter equals 1: HI/LO <= pending, busy<=0, counter<=0.
  - busy is therefore high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES); the results are visible in the same cycle busy drops.
- start=1 while busy=1: ignored entirely (no state change). The hazard unit guarantees this never happens; the bench flags it as a warning.
- HI/LO outputs are the raw registers, unaffected by pending values, until commit.
- Counter width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Parameters are required to be >=1; with a value of 1, commit occurs on the edge after T0.
- No X propagation: op codes 6/7 with start=1 are a no-op.

Decomposition:
- Shared package/header holds:
  - op encodings (MD_MULT..MD_MTLO), matching the values the E-stage control decoder emits;
  - default latency constants.
- No sub-module: the arithmetic is inline (operator-based), with a single counter FSM of two states, IDLE/BUSY, where the BUSY state is encoded by busy=1.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> HI=0, LO=0, busy=0 on every cycle.
- MULT A=0xFFFFFFFF, B=2 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat with MULTU -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- Edge cases:
  - DIVU with B=0 after MTHI A=0x12345678 and MTLO A=0x9ABCDEF0 -> busy high 10 cycles; HI/LO remain 0x12345678/0x9ABCDEF0.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start while busy: MULT 3*4, then at cycle 2 start DIV 100/7 -> second request ignored; after 5 cycles HI=0, LO=12; busy low.
- Reset mid-op: DIV 100/7, assert reset at cycle 4 asynchronously (between edges) -> busy=0 and HI=LO=0 immediately; after release no commit occurs.
